pcache_tag_ctrl: RTL and testbench
==================================

Name: pcache_tag_ctrl

Overview:
- Control stage directly upstream of the per-tile primitive parameter cache.
- Owns the cache's single shared address port (prim_tag) and its write strobe (pcache_write).
- Allocates sequential tags to incoming parsed triangles, writes them, and arbitrates TSP-side read requests onto the same port.
- Tracks the one-cycle BRAM read latency and flags when read data is valid at the cache outputs. Triangle data buses route straight from the parser to the cache; only control passes through this block.

Parameters:
- TAG_W, 10, tag/address width.
- ENTRIES, 1024, cache depth; must be ≤ 2^TAG_W.
- RD_LAT, 1, cycles from address presented to cache data valid (1 = registered BRAM read).

Ports:
- clock  in  1  single clock for all logic.
- reset_n  in  1  asynchronous active-low reset.
- tile_start  in  1  pulse; clears allocator for a new tile.
- prim_valid  in  1  parser presents a triangle.
- prim_ready  out  1  triangle accepted this cycle when prim_valid & prim_ready.
- alloc_tag  out  TAG_W  tag given to the accepted triangle; valid with alloc_valid.
- alloc_valid  out  1  registered pulse, one cycle after acceptance.
- alloc_count  out  TAG_W+1  number of tags allocated this tile.
- alloc_full  out  1  alloc_count == ENTRIES.
- rd_valid  in  1  TSP requests a read of rd_tag.
- rd_tag  in  TAG_W  tag to read.
- rd_ready  out  1  read accepted this cycle.
- rd_data_valid  out  1  cache outputs hold data for rd_tag_out.
- rd_tag_out  out  TAG_W  tag whose data is currently valid.
- prim_tag  out  TAG_W  address to parameter cache.
- pcache_write  out  1  cache write strobe.

Behaviour:
- Reset (async, reset_n=0) sets:
  - next_tag=0, alloc_count=0, alloc_full=0, alloc_valid=0.
  - rd_data_valid=0, rd_tag_out=0, prim_tag=0, pcache_write=0.
  - The RD_LAT shift pipe is cleared.
- The address port is combinational from the arbiter:
  - Write accept: prim_tag=next_tag, pcache_write=1.
  - Read accept: prim_tag=rd_tag, pcache_write=0.
  - Idle: prim_tag holds its last value, pcache_write=0.
- prim_ready = !alloc_full & !tile_start.
- rd_ready = !(prim_valid & prim_ready) & !tile_start. Writes have strict priority; a read stalls while a write is accepted.
- Write accept (prim_valid & prim_ready):
  - Next cycle: alloc_tag=old next_tag, alloc_valid=1.
  - next_tag+1, alloc_count+1.
  - alloc_full asserts registered when the count reaches ENTRIES.
- Read accept (rd_valid & rd_ready): the tag enters an RD_LAT-deep pipe. RD_LAT cycles later rd_data_valid=1 for one cycle and rd_tag_out=that tag. Back-to-back reads give back-to-back valid pulses.
- Read of an unallocated tag (≥ alloc_count): permitted, no error; the data is stale.
- tile_start:
  - Next cycle: next_tag=0, alloc_count=0, alloc_full=0.
  - Blocks both accepts in its own cycle.
  - Does not flush the read pipe; in-flight rd_data_valid still fires.
- Full: prim_ready=0 until tile_start. next_tag never wraps; no write is ever issued at tag ENTRIES.
- Write followed by a read of the same tag next cycle returns the new data. The cache write precedes the read edge.
- Simultaneous write and read in the same cycle: the write is accepted, the read is held with rd_ready=0.
- Reset mid-operation: all state clears immediately and in-flight read valids are dropped.

Decomposition:
- Shared pvr package holds:
  - PCACHE_ENTRIES=1024.
  - PCACHE_TAG_W=10.
  - PCACHE_RD_LAT=1.
  - A typedef for the tag type.
- One natural sub-module: pcache_rd_pipe, a parameterised valid+tag delay line of depth RD_LAT.
- Arbiter and allocator stay in the top.

Test Plan:
- Reset mid-stream with alloc_count=5 → all outputs 0 asynchronously; first accept after release gets alloc_tag=0.
- 3 triangles back-to-back after tile_start:
  - pcache_write high 3 cycles, prim_tag=0,1,2.
  - alloc_valid pulses with alloc_tag=0,1,2.
  - alloc_count=3.
- Fill 1024 triangles:
  - alloc_full=1, prim_ready=0 on the 1025th request, no pcache_write.
  - tile_start → next accept gets tag 0, alloc_full=0.
- Simultaneous prim_valid and rd_valid(rd_tag=7):
  - Cycle 0: write wins, rd_ready=0.
  - Cycle 1: read accepted, prim_tag=7.
  - Cycle 2: rd_data_valid=1, rd_tag_out=7.
- Reads of tags 4,9,4 back-to-back → rd_data_valid high 3 consecutive cycles with rd_tag_out=4,9,4.
- Write tag 2 then read tag 2 next cycle → data matches written value. Also assert tile_start during an in-flight read → that read's rd_data_valid still pulses.

Source files
------------

// File: rtl/pcache_tag_ctrl_pkg.sv
// Shared constants and types for the per-tile primitive parameter cache.
//   PCACHE_ENTRIES : cache depth in triangles
//   PCACHE_TAG_W   : tag / cache address width
//   PCACHE_RD_LAT  : cycles from address presented to read data valid
package pcache_tag_ctrl_pkg;

  localparam int PCACHE_ENTRIES = 1024;
  localparam int PCACHE_TAG_W   = 10;
  localparam int PCACHE_RD_LAT  = 1;

  typedef logic [PCACHE_TAG_W-1:0] pcache_tag_t;

endpackage

// File: rtl/pcache_tag_ctrl_rd_pipe.sv
// pcache_rd_pipe: valid + tag delay line that tracks the cache read latency.
//   clock, reset_n : clock, async active-low reset (clears every stage)
//   i_valid, i_tag : read accepted this cycle and its tag
//   o_valid, o_tag : read data for o_tag is valid at the cache outputs
// Tag stages only load behind a valid bit, so o_tag holds the last read tag.
module pcache_rd_pipe #(
  parameter int TAG_W = 10,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_valid,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag
);

  logic [DEPTH-1:0] r_vld;
  logic [TAG_W-1:0] r_tag [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      if (i_valid) r_tag[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_tag   = r_tag[DEPTH-1];

endmodule

// File: rtl/pcache_tag_ctrl.sv
// pcache_tag_ctrl: owns the parameter cache address port. Allocates sequential
// tags to parsed triangles (writes), arbitrates TSP reads onto the same port
// and flags when read data is valid at the cache outputs.
//   clock, reset_n                 : clock, async active-low reset
//   tile_start                     : pulse, restarts tag allocation
//   prim_valid / prim_ready        : triangle handshake from the parser
//   alloc_tag / alloc_valid        : tag given to the accepted triangle
//   alloc_count / alloc_full       : tags used this tile / cache full
//   rd_valid / rd_tag / rd_ready   : TSP read request handshake
//   rd_data_valid / rd_tag_out     : cache read data valid for rd_tag_out
//   prim_tag / pcache_write        : cache address and write strobe
module pcache_tag_ctrl
  import pcache_tag_ctrl_pkg::*;
#(
  parameter int TAG_W   = PCACHE_TAG_W,
  parameter int ENTRIES = PCACHE_ENTRIES,
  parameter int RD_LAT  = PCACHE_RD_LAT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tile_start,
  input  logic             prim_valid,
  output logic             prim_ready,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             alloc_valid,
  output logic [TAG_W:0]   alloc_count,
  output logic             alloc_full,
  input  logic             rd_valid,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_ready,
  output logic             rd_data_valid,
  output logic [TAG_W-1:0] rd_tag_out,
  output logic [TAG_W-1:0] prim_tag,
  output logic             pcache_write
);

  localparam int CNT_W = TAG_W + 1;

  logic [CNT_W-1:0] r_alloc_count;
  logic             r_alloc_full;
  logic             r_alloc_valid;
  logic [TAG_W-1:0] r_alloc_tag;
  logic [TAG_W-1:0] r_prim_tag;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [TAG_W-1:0] w_next_tag;

  // The next free tag always equals the number allocated; full stops the
  // count at ENTRIES, so the truncation never wraps into a live tag.
  assign w_next_tag = r_alloc_count[TAG_W-1:0];

  assign prim_ready = !r_alloc_full && !tile_start;
  assign w_wr_acc   = prim_valid && prim_ready;
  assign rd_ready   = !w_wr_acc && !tile_start;
  assign w_rd_acc   = rd_valid && rd_ready;

  // Idle cycles keep the last address on the port.
  always_comb begin
    prim_tag = r_prim_tag;
    if (w_wr_acc)      prim_tag = w_next_tag;
    else if (w_rd_acc) prim_tag = rd_tag;
  end

  assign pcache_write = w_wr_acc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_alloc_count <= '0;
      r_alloc_full  <= 1'b0;
      r_alloc_valid <= 1'b0;
      r_alloc_tag   <= '0;
      r_prim_tag    <= '0;
    end else begin
      r_alloc_valid <= w_wr_acc;
      r_prim_tag    <= prim_tag;
      if (w_wr_acc) r_alloc_tag <= w_next_tag;
      if (tile_start) begin
        r_alloc_count <= '0;
        r_alloc_full  <= 1'b0;
      end else if (w_wr_acc) begin
        r_alloc_count <= r_alloc_count + 1'b1;
        r_alloc_full  <= (r_alloc_count == CNT_W'(ENTRIES - 1));
      end
    end
  end

  assign alloc_count = r_alloc_count;
  assign alloc_full  = r_alloc_full;
  assign alloc_valid = r_alloc_valid;
  assign alloc_tag   = r_alloc_tag;

  // tile_start does not touch this pipe: in-flight reads still complete.
  pcache_rd_pipe #(
    .TAG_W (TAG_W),
    .DEPTH (RD_LAT)
  ) u_rd_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .i_valid (w_rd_acc),
    .i_tag   (rd_tag),
    .o_valid (rd_data_valid),
    .o_tag   (rd_tag_out)
  );

endmodule

// File: tb/tb_pcache_tag_ctrl.sv
// Scoreboard bench for pcache_tag_ctrl. The driver predicts handshakes and the
// address port from a tag-allocation model and queues expected alloc/read
// responses; a negedge monitor pops them as the DUT presents them. A small
// behavioural BRAM on the address port checks write-then-read data ordering.
module tb_pcache_tag_ctrl;
  import pcache_tag_ctrl_pkg::*;

  localparam int ENT = PCACHE_ENTRIES;

  typedef struct {
    int          due;
    pcache_tag_t tag;
    logic [31:0] data;
    bit          known;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              tile_start, prim_valid, rd_valid;
  pcache_tag_t       rd_tag;
  logic              prim_ready, alloc_valid, alloc_full, rd_ready;
  logic              rd_data_valid, pcache_write;
  pcache_tag_t       alloc_tag, rd_tag_out, prim_tag;
  logic [PCACHE_TAG_W:0] alloc_count;

  pcache_tag_ctrl dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .tile_start    (tile_start),
    .prim_valid    (prim_valid),
    .prim_ready    (prim_ready),
    .alloc_tag     (alloc_tag),
    .alloc_valid   (alloc_valid),
    .alloc_count   (alloc_count),
    .alloc_full    (alloc_full),
    .rd_valid      (rd_valid),
    .rd_tag        (rd_tag),
    .rd_ready      (rd_ready),
    .rd_data_valid (rd_data_valid),
    .rd_tag_out    (rd_tag_out),
    .prim_tag      (prim_tag),
    .pcache_write  (pcache_write)
  );

  always #5 clock = ~clock;

  // behavioural registered-read BRAM sitting on the DUT's address port
  logic [31:0] prim_data;
  logic [31:0] mem [ENT];
  logic [31:0] bram_q;
  always @(posedge clock) begin
    if (pcache_write) mem[prim_tag] <= prim_data;
    bram_q <= mem[prim_tag];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  exp_t q_al[$];
  exp_t q_rd[$];

  // reference model state
  int          m_count = 0;
  pcache_tag_t m_last  = '0;
  logic [31:0] m_mem [ENT];
  bit          m_known [ENT];

  // one clock cycle: drive at posedge+1, check combinational outputs at +4
  task automatic cycle(input bit pv, input bit rv, input int rt, input bit ts);
    bit wr, rd, exp_pr, exp_rr;
    pcache_tag_t t, exp_tag;
    exp_t e;
    t          = pcache_tag_t'(rt);
    prim_valid = pv;
    rd_valid   = rv;
    rd_tag     = t;
    tile_start = ts;
    prim_data  = $urandom;
    #3;
    exp_pr  = (m_count < ENT) && !ts;
    wr      = pv && exp_pr;
    exp_rr  = !wr && !ts;
    rd      = rv && exp_rr;
    exp_tag = wr ? pcache_tag_t'(m_count) : (rd ? t : m_last);
    chk("prim_ready", 32'(prim_ready), 32'(exp_pr));
    chk("rd_ready", 32'(rd_ready), 32'(exp_rr));
    chk("pcache_write", 32'(pcache_write), 32'(wr));
    chk("prim_tag", 32'(prim_tag), 32'(exp_tag));
    chk("alloc_count", 32'(alloc_count), 32'(m_count));
    chk("alloc_full", 32'(alloc_full), 32'(m_count == ENT));
    if (wr) begin
      e.due = cyc + 1; e.tag = exp_tag; e.data = prim_data; e.known = 1'b1;
      q_al.push_back(e);
      m_mem[m_count]   = prim_data;
      m_known[m_count] = 1'b1;
      m_count++;
    end
    if (rd) begin
      e.due = cyc + PCACHE_RD_LAT; e.tag = t; e.data = m_mem[rt]; e.known = m_known[rt];
      q_rd.push_back(e);
    end
    m_last = exp_tag;
    if (ts) m_count = 0;
    @(posedge clock);
    #1;
  endtask

  exp_t ea, er;
  always @(negedge clock) begin
    if (reset_n) begin
      if (alloc_valid) begin
        if (q_al.size() == 0) chk("alloc_unexpected", 32'(alloc_valid), 32'd0);
        else begin
          ea = q_al.pop_front();
          chk("alloc_cycle", 32'(cyc), 32'(ea.due));
          chk("alloc_tag", 32'(alloc_tag), 32'(ea.tag));
        end
      end else if (q_al.size() > 0 && q_al[0].due <= cyc) begin
        ea = q_al.pop_front();
        chk("alloc_valid_missing", 32'(alloc_valid), 32'd1);
      end
      if (rd_data_valid) begin
        if (q_rd.size() == 0) chk("rd_unexpected", 32'(rd_data_valid), 32'd0);
        else begin
          er = q_rd.pop_front();
          chk("rd_cycle", 32'(cyc), 32'(er.due));
          chk("rd_tag_out", 32'(rd_tag_out), 32'(er.tag));
          if (er.known) chk("rd_data", bram_q, er.data);
        end
      end else if (q_rd.size() > 0 && q_rd[0].due <= cyc) begin
        er = q_rd.pop_front();
        chk("rd_valid_missing", 32'(rd_data_valid), 32'd1);
      end
    end
  end

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_alloc_valid"}, 32'(alloc_valid), 32'd0);
    chk({nm, "_alloc_count"}, 32'(alloc_count), 32'd0);
    chk({nm, "_alloc_full"}, 32'(alloc_full), 32'd0);
    chk({nm, "_rd_data_valid"}, 32'(rd_data_valid), 32'd0);
    chk({nm, "_rd_tag_out"}, 32'(rd_tag_out), 32'd0);
    chk({nm, "_prim_tag"}, 32'(prim_tag), 32'd0);
    chk({nm, "_pcache_write"}, 32'(pcache_write), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < ENT; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    reset_n = 1'b0; tile_start = 1'b0; prim_valid = 1'b0; rd_valid = 1'b0;
    rd_tag = '0; prim_data = '0;
    #12;
    check_reset_outputs("por");
    @(posedge clock); #1;
    reset_n = 1'b1;

    // three back-to-back triangles after tile_start
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // write wins over a simultaneous read, read goes next cycle
    cycle(1, 1, 7, 0);
    cycle(0, 1, 7, 0);
    cycle(0, 0, 0, 0);

    // back-to-back reads 4,9,4
    cycle(0, 1, 4, 0);
    cycle(0, 1, 9, 0);
    cycle(0, 1, 4, 0);
    cycle(0, 0, 0, 0);

    // write tag 2 then read it the next cycle
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(0, 1, 2, 0);

    // tile_start right behind an accepted read: the read still completes
    cycle(0, 1, 5, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);

    // async reset mid-stream with 5 allocated and a read in flight
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    cycle(0, 1, 3, 0);
    prim_valid = 1'b0; rd_valid = 1'b0; tile_start = 1'b0;
    reset_n = 1'b0;
    q_al.delete();
    q_rd.delete();
    #1;
    check_reset_outputs("midrst");
    m_count = 0;
    m_last  = '0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // fill the cache, push past full, then restart the tile
    cycle(0, 0, 0, 1);
    for (int i = 0; i < ENT; i++) cycle(1, $urandom_range(0, 1), $urandom_range(0, ENT - 1), 0);
    cycle(1, 1, 1000, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, ENT - 1),
            ($urandom_range(0, 49) == 0));

    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    chk("queues_drained", 32'(q_al.size() + q_rd.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
